// File: rtl/series_engine.sv
// series_engine: multi-cycle geometric series evaluator, result = sum x^i for i=0..n.
// Define SERIES_OVF_EN to add the sticky ovf output.
module series_engine #(
   parameter int DATA_W = 16,
   parameter int IN_W   = 8,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [IN_W-1:0]   data_in,
   output logic              ready,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] result
`ifdef SERIES_OVF_EN
   ,
   output logic              ovf
`endif
);

   localparam int X_WORDS = DATA_W / IN_W;
   localparam int IDX_W   = (X_WORDS > 1) ? $clog2(X_WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(X_WORDS - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_GET_N = 3'd1,
      S_GET_X = 3'd2,
      S_WAIT  = 3'd3,
      S_MUL   = 3'd4,
      S_ADD   = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   state_t state;
   state_t next;

   logic [CNT_W-1:0]  n;
   logic [CNT_W-1:0]  count;
   logic [IDX_W-1:0]  idx;
   logic [DATA_W-1:0] x;
   logic [DATA_W-1:0] t;
   logic [DATA_W-1:0] r;
   logic              last_term;

   assign last_term = (count == n);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= next;
   end

   always_comb begin
      next = S_IDLE;
      case (state)
         S_IDLE:  next = start ? S_GET_N : S_IDLE;
         S_GET_N: next = S_GET_X;
         S_GET_X: next = (idx == LAST_IDX) ? S_WAIT : S_GET_X;
         S_WAIT:  next = start ? S_WAIT : S_MUL;
         S_MUL:   next = last_term ? S_DONE : S_ADD;
         S_ADD:   next = S_MUL;
         S_DONE:  next = S_IDLE;
         default: next = S_IDLE;
      endcase
      // abort only matters while busy; IDLE and DONE ignore it
      if (abort && busy) next = S_IDLE;
   end

   always_comb begin
      ready = 1'b0;
      busy  = 1'b0;
      done  = 1'b0;
      case (state)
         S_IDLE:  ready = 1'b1;
         S_DONE:  done  = 1'b1;
         S_GET_N,
         S_GET_X,
         S_WAIT,
         S_MUL,
         S_ADD:   busy  = 1'b1;
         default: ;
      endcase
   end

`ifdef SERIES_OVF_EN
   logic [2*DATA_W-1:0] prod_w;
   logic [DATA_W:0]     sum_w;
   assign prod_w = {{DATA_W{1'b0}}, t} * {{DATA_W{1'b0}}, x};
   assign sum_w  = {1'b0, r} + {1'b0, t};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf <= 1'b0;
      end else begin
         case (state)
            S_WAIT: ovf <= 1'b0;
            S_MUL:  if (!last_term) ovf <= ovf | (|prod_w[2*DATA_W-1:DATA_W]);
            S_ADD:  ovf <= ovf | sum_w[DATA_W];
            default: ;
         endcase
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         n      <= '0;
         count  <= '0;
         idx    <= '0;
         x      <= '0;
         t      <= '0;
         r      <= '0;
         result <= '0;
      end else begin
         case (state)
            S_GET_N: begin
               n     <= data_in[CNT_W-1:0];
               count <= '0;
               idx   <= '0;
            end
            S_GET_X: begin
               x[int'(idx)*IN_W +: IN_W] <= data_in;
               idx <= idx + 1'b1;
            end
            S_WAIT: begin
               t <= DATA_W'(1);
               r <= DATA_W'(1);
            end
            S_MUL: if (!last_term) t <= t * x;
            S_ADD: begin
               r     <= r + t;
               count <= count + 1'b1;
            end
            S_DONE: result <= r;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_series_engine.sv
// tb_series_engine: directed and random runs checked against a series model.
// Build with SERIES_OVF_EN defined to also check the ovf flag.
module tb_series_engine;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        abort;
   logic [7:0]  data_in;
   logic        ready;
   logic        busy;
   logic        done;
   logic [15:0] result;
`ifdef SERIES_OVF_EN
   logic        ovf;
`endif

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   series_engine #(.DATA_W(16), .IN_W(8), .CNT_W(8)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .abort(abort),
      .data_in(data_in),
      .ready(ready),
      .busy(busy),
      .done(done),
      .result(result)
`ifdef SERIES_OVF_EN
      ,
      .ovf(ovf)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // sum of powers of x, wrapped to 16 bits
   function automatic logic [15:0] ref_sum(input int n, input logic [15:0] x);
      longint acc = 0;
      longint pw  = 1;
      for (int i = 0; i <= n; i++) begin
         acc = (acc + pw) % 65536;
         pw  = (pw * x) % 65536;
      end
      return acc[15:0];
   endfunction

   function automatic logic ref_ovf(input int n, input logic [15:0] x);
      longint tm = 1;
      longint sm = 1;
      logic   o  = 1'b0;
      for (int i = 0; i < n; i++) begin
         tm = tm * x;
         if (tm > 65535) o = 1'b1;
         tm = tm % 65536;
         sm = sm + tm;
         if (sm > 65535) o = 1'b1;
         sm = sm % 65536;
      end
      return o;
   endfunction

   // load n and x, hold start in WAIT, then release; ends on the WAIT exit edge
   task automatic load(input int n, input logic [15:0] x, input int hold);
      start   = 1'b1;
      data_in = 8'hA5;
      step();
      data_in = 8'(n);
      step();
      data_in = x[7:0];
      step();
      data_in = x[15:8];
      step();
      for (int i = 0; i < hold; i++) step();
      start = 1'b0;
      step();
   endtask

   task automatic run(input string tag, input int n, input logic [15:0] x,
                      input int hold);
      int cyc = 0;
      load(n, x, hold);
      while (done !== 1'b1 && cyc < 2000) begin
         step();
         cyc++;
      end
      chk({tag, "_latency"}, cyc, 2 * n + 1);
      chk({tag, "_busy_done"}, {31'd0, busy}, 0);
      step();
      chk({tag, "_result"}, {16'd0, result}, {16'd0, ref_sum(n, x)});
      chk({tag, "_ready_after"}, {30'd0, ready, done}, 32'd2);
`ifdef SERIES_OVF_EN
      chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, ref_ovf(n, x)});
`endif
   endtask

   initial begin
      logic [15:0] prev;
      logic [15:0] rx;
      int          rn;
      int          seen;

      rst     = 1'b1;
      start   = 1'b0;
      abort   = 1'b0;
      data_in = 8'h00;
      #1;
      chk("rst_ready", {31'd0, ready}, 1);
      chk("rst_busy_done", {30'd0, busy, done}, 0);
      chk("rst_result", {16'd0, result}, 0);
`ifdef SERIES_OVF_EN
      chk("rst_ovf", {31'd0, ovf}, 0);
`endif
      step();
      step();
      rst = 1'b0;
      step();

      run("n3x2", 3, 16'h0002, 0);
      run("n0", 0, 16'h1234, 0);
      run("hold5", 3, 16'h0002, 5);
      run("wrap", 2, 16'h0100, 0);
      run("n2x2", 2, 16'h0002, 0);

      // abort/start handling in IDLE and GET_N
      abort = 1'b1;
      step();
      chk("abort_idle", {31'd0, ready}, 1);
      start = 1'b1;
      step();
      chk("start_with_abort", {31'd0, busy}, 1);
      start = 1'b0;
      step();
      chk("abort_getn", {31'd0, ready}, 1);
      abort = 1'b0;

      // abort during the second ADD
      prev = result;
      load(3, 16'h0002, 0);
      step();
      step();
      step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_add_ready", {31'd0, ready}, 1);
      chk("abort_add_result", {16'd0, result}, {16'd0, prev});
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         if (done === 1'b1) seen++;
         step();
      end
      chk("abort_no_done", seen, 0);

      for (int k = 0; k < 20; k++) begin
         rn = $urandom_range(0, 15);
         rx = 16'($urandom);
         run("rand", rn, rx, $urandom_range(0, 3));
      end

      // async reset while in MUL, between edges
      load(5, 16'h0003, 0);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_ready", {31'd0, ready}, 1);
      chk("midrst_result", {16'd0, result}, 0);
      #1;
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (done === 1'b1) seen++;
      end
      chk("midrst_no_done", seen, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
